// File: rtl/dp_mem_ctrl.sv
// rtl/dp_mem_ctrl.sv - parametrised true dual-port memory controller with post-reset clear
module dp_mem_ctrl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 1024,
  parameter int READ_LAT       = 1,
  parameter bit COLLIDE_B_WINS = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  input  logic              en_a,
  input  logic              wren_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  output logic              valid_a,
  output logic              err_a,
  input  logic              en_b,
  input  logic              wren_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              valid_b,
  output logic              err_b,
  output logic              collision
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Range checks use one extra bit so DEPTH == 2^ADDR_W is representable.
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             run;
  logic             in_a, in_b;
  logic             wr_a, wr_b, rd_a, rd_b;
  logic             coll, we_a, we_b;
  logic [IDX_W-1:0] idx_a, idx_b;

  logic              v1_a, v1_b, e1_a, e1_b, c1;
  logic [DATA_W-1:0] d1_a, d1_b;

  // Request decode; nothing is accepted while clearing or while reset is asserted.
  assign run   = (state_q == RUN) && !reset;
  assign in_a  = {1'b0, address_a} < DEPTH_L;
  assign in_b  = {1'b0, address_b} < DEPTH_L;
  assign idx_a = address_a[IDX_W-1:0];
  assign idx_b = address_b[IDX_W-1:0];
  assign wr_a  = run && en_a && wren_a && in_a;
  assign wr_b  = run && en_b && wren_b && in_b;
  assign rd_a  = run && en_a && !wren_a;
  assign rd_b  = run && en_b && !wren_b;
  assign coll  = wr_a && wr_b && (address_a == address_b);
  assign we_a  = wr_a && !(coll && COLLIDE_B_WINS);
  assign we_b  = wr_b && !(coll && !COLLIDE_B_WINS);
  assign busy  = (state_q == CLEAR);

  // Next-state logic: clear walks the array once, then the controller stays in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt_q == CNT_LAST) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RUN;
    endcase
    if (reset) state_d = CLEAR_ON_RESET ? CLEAR : RUN;
  end

  // State register and clear address counter.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    if (reset)
      cnt_q <= '0;
    else if (state_q == CLEAR)
      cnt_q <= cnt_q + 1'b1;
  end

  // Storage array: clear writes, then port writes with the losing collision write dropped.
  always_ff @(posedge clk) begin
    if ((state_q == CLEAR) && !reset) mem[cnt_q] <= '0;
    if (we_a) mem[idx_a] <= data_a;
    if (we_b) mem[idx_b] <= data_b;
  end

  // First read stage; samples the array before this edge's writes land (read-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_a <= 1'b0;
      v1_b <= 1'b0;
      e1_a <= 1'b0;
      e1_b <= 1'b0;
      c1   <= 1'b0;
      d1_a <= '0;
      d1_b <= '0;
    end else begin
      v1_a <= rd_a;
      v1_b <= rd_b;
      e1_a <= run && en_a && !in_a;
      e1_b <= run && en_b && !in_b;
      c1   <= coll;
      if (rd_a) d1_a <= in_a ? mem[idx_a] : '0;
      if (rd_b) d1_b <= in_b ? mem[idx_b] : '0;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      // Optional output register stage; q holds until the next completed read.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_a   <= 1'b0;
          valid_b   <= 1'b0;
          err_a     <= 1'b0;
          err_b     <= 1'b0;
          collision <= 1'b0;
          q_a       <= '0;
          q_b       <= '0;
        end else begin
          valid_a   <= v1_a;
          valid_b   <= v1_b;
          err_a     <= e1_a;
          err_b     <= e1_b;
          collision <= c1;
          if (v1_a) q_a <= d1_a;
          if (v1_b) q_b <= d1_b;
        end
      end
    end else begin : g_lat1
      assign valid_a   = v1_a;
      assign valid_b   = v1_b;
      assign err_a     = e1_a;
      assign err_b     = e1_b;
      assign collision = c1;
      assign q_a       = d1_a;
      assign q_b       = d1_b;
    end
  endgenerate

endmodule

// File: doc/dp_mem_ctrl.md
# dp_mem_ctrl

Parametrised true dual-port synchronous memory controller. It is the next generation of the 16-bit two-port memory that sits beside the CPU. It adds configurable data width, depth and read latency, plus automatic clear after reset, read-valid and error flags, and a defined write-write collision policy. Port A serves the CPU datapath and port B serves the external/DMA side. Both ports are fully independent within one clock domain.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 16, address port width in bits
- DEPTH, 1024, number of words; must satisfy DEPTH <= 2^ADDR_W
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2 (2 adds an output register)
- COLLIDE_B_WINS, 0, write-write same-address policy: 0 = port A's data is stored, 1 = port B's data is stored
- CLEAR_ON_RESET, 1, 1 = zero all words after reset
- clk  input  1  single clock; all logic is rising-edge
- reset  input  1  synchronous, active-high reset
- busy  output  1  clear sequence in progress; all port requests are ignored while high
- en_a  input  1  port A access request, sampled each edge
- wren_a  input  1  port A write (1) or read (0); qualified by en_a
- address_a  input  ADDR_W  port A word address
- data_a  input  DATA_W  port A write data
- q_a  output  DATA_W  port A read data
- valid_a  output  1  q_a holds a new read result (one-cycle pulse per read)
- err_a  output  1  out-of-range access pulse (address >= DEPTH)
- en_b, wren_b, address_b, data_b, q_b, valid_b, err_b: same as port A, for port B
- collision  output  1  write-write same-address pulse

## Operation
- FSM states: CLEAR and RUN.
- Any edge with reset=1:
  - next state is CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
  - clear counter is set to 0.
  - all pipeline valid/err/collision stages are flushed.
  - q_a and q_b are set to 0.
  - memory contents are not touched by reset itself.
- CLEAR state:
  - one word is written per edge: mem[cnt] <= 0, then cnt increments.
  - after the write to DEPTH-1, the state moves to RUN.
  - en_a/en_b are ignored; valid, err and collision stay 0.
- RUN state, per port, when en_x=1 and address_x < DEPTH:
  - write: mem[address_x] <= data_x.
  - read: data is returned READ_LAT cycles later with valid_x=1.
- Read-during-write is read-first, on the same port or across ports: a read returns the pre-write contents.
- Both ports write the same in-range address on the same edge:
  - only the winning port's data is stored.
  - collision pulses with the same latency as valid.
- A read on one port plus a write on the other port to the same address is not a collision.
- Out-of-range access (address_x >= DEPTH):
  - a write is suppressed.
  - a read returns q_x=0 with valid_x=1.
  - err_x pulses in both cases.
- Address bits are compared at full ADDR_W width; addresses are never truncated or wrapped.
- q_x holds its last value when no read completes. valid_x qualifies each new result.

## Timing
- Reset values of outputs: q_a=q_b=0, valid_a=valid_b=0, err_a=err_b=0, collision=0. busy=1 when CLEAR_ON_RESET=1, else 0.
- busy stays high for exactly DEPTH cycles after the first edge with reset=0.
  - The first request accepted is on edge DEPTH+1 after release.
- Read issued at edge t: q_x/valid_x are updated at edge t+READ_LAT and are visible in the following cycle.
- Throughput is one access per port per cycle. Back-to-back reads produce back-to-back valid pulses.
- err_x and collision are aligned with valid_x, i.e. they also appear READ_LAT edges after the request.
- A write is visible to a read issued on the next edge.
- Reset asserted mid-CLEAR or mid-RUN:
  - in-flight reads are dropped (no valid pulse).
  - the clear sequence restarts from address 0.

## Test plan
- Clear after reset (DEPTH=16, READ_LAT=1, CLEAR_ON_RESET=1):
  - Reset is held for 2 cycles, then released.
  - Required: busy=1 for 16 cycles.
  - A request issued while busy=1 is ignored, with no valid pulse.
  - A read of address 5 after busy falls returns q_a=0x0000 with valid_a=1 one cycle later.
- Write then read: A writes 0x1234 to address 3; B reads address 3 on the next cycle.
  - Required: q_b=0x1234 and valid_b=1 after READ_LAT.
  - With READ_LAT=2, the result appears one cycle later.
- Collision (COLLIDE_B_WINS=0): A writes 0xAAAA and B writes 0x5555 to address 7 on the same edge.
  - Required: collision pulses once.
  - A later read of address 7 returns 0xAAAA.
  - Repeat with COLLIDE_B_WINS=1: the read returns 0x5555.
- Read-first: address 2 holds 0x0011. A writes 0x00FF to address 2 while B reads address 2 on the same edge.
  - Required: q_b=0x0011.
  - The next read of address 2 returns 0x00FF.
- Out of range (DEPTH=16): A writes 0xBEEF to address 16, then reads address 16.
  - Required: err_a pulses twice; the read gives q_a=0 with valid_a=1.
  - Address 0 is unchanged.
- Reset mid-read: a read is issued, and reset is asserted on the next edge before the read completes (READ_LAT=2).
  - Required: no valid pulse; q=0; busy=1; the clear restarts from address 0.
